// File: rtl/cmul_frac_pipe.sv
// cmul_frac_pipe: 3-stage pipeline computing y = round(x*K/2^S) with a rounding mode carried per sample.
// Define CMUL_FRAC_SAT_EN to saturate out-of-range results; otherwise they wrap to the low W bits.
module cmul_frac_pipe #(
   parameter int W = 5,
   parameter int K = 7,
   parameter int S = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [W-1:0] x,
   input  logic [1:0]          mode,
   input  logic                x_valid,
   output logic                x_ready,
   output logic signed [W-1:0] y,
   output logic                y_valid,
   input  logic                y_ready,
   output logic                ovf
);
   localparam int PW = W + 8;
   localparam int QW = W + 9;
   localparam logic signed [PW-1:0] kc   = PW'(K);
   localparam logic signed [QW-1:0] zero = QW'(0);
   localparam logic signed [QW-1:0] half = QW'(2 ** (S - 1));
   localparam logic signed [QW-1:0] frac = QW'(2 ** S - 1);
   localparam logic signed [QW-1:0] ymax = QW'(2 ** (W - 1) - 1);
   localparam logic signed [QW-1:0] ymin = QW'(-(2 ** (W - 1)));
   logic                en, v1, v2, hi, lo;
   logic signed [W-1:0] x1, yn;
   logic [1:0]          m1, m2;
   logic signed [PW-1:0] p2;
   logic signed [QW-1:0] bias, q;
   assign en = y_ready | ~y_valid;
   assign x_ready = en;
   // S1 captures the sample and its mode; S2 forms the exact product at full width
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         v1 <= 1'b0;
         x1 <= '0;
         m1 <= '0;
         v2 <= 1'b0;
         p2 <= '0;
         m2 <= '0;
      end else if (en) begin
         v1 <= x_valid;
         x1 <= x;
         m1 <= mode;
         v2 <= v1;
         p2 <= PW'(x1) * kc;
         m2 <= m1;
      end
   // Mode-dependent bias before the arithmetic shift: negative bias-up gives truncation toward zero
   always_comb begin
      bias = m2 == 2'd1 ? zero : m2 == 2'd2 ? half : p2[PW-1] ? frac : zero;
      q = (QW'(p2) + bias) >>> S;
      hi = q > ymax;
      lo = q < ymin;
`ifdef CMUL_FRAC_SAT_EN
      yn = hi ? {1'b0, {(W-1){1'b1}}} : lo ? {1'b1, {(W-1){1'b0}}} : q[W-1:0];
`else
      yn = q[W-1:0];
`endif
   end
   // S3 registers the result and the sticky overflow flag; everything holds while stalled
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         y <= '0;
         y_valid <= 1'b0;
         ovf <= 1'b0;
      end else if (en) begin
         y_valid <= v2;
         if (v2) y <= yn;
         if (v2 && (hi || lo)) ovf <= 1'b1;
      end
endmodule

// File: tb/tb_cmul_frac_pipe.sv
// tb_cmul_frac_pipe: directed vector table plus stall, mid-flight reset and overflow sequences.
module tb_cmul_frac_pipe;
   typedef struct {
      logic signed [4:0] x;
      logic [1:0]        m;
      logic signed [4:0] y;
   } vec_t;
`ifdef CMUL_FRAC_SAT_EN
   localparam int K9_Y = 15;
`else
   localparam int K9_Y = -16;
`endif
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic signed [4:0] x, y, yk;
   logic [1:0]        mode;
   logic              x_valid, y_ready, x_ready, y_valid, ovf, xk_ready, yk_valid, ovfk;
   int                tests = 0;
   int                fails = 0;
   vec_t              tv[$];
   int                got[$];
   cmul_frac_pipe #(.W(5), .K(7), .S(3)) dut (
      .clk(clk), .reset(reset), .x(x), .mode(mode), .x_valid(x_valid), .x_ready(x_ready),
      .y(y), .y_valid(y_valid), .y_ready(y_ready), .ovf(ovf)
   );
   cmul_frac_pipe #(.W(5), .K(9), .S(3)) dut9 (
      .clk(clk), .reset(reset), .x(x), .mode(mode), .x_valid(x_valid), .x_ready(xk_ready),
      .y(yk), .y_valid(yk_valid), .y_ready(y_ready), .ovf(ovfk)
   );
   // free-running clock, period 10
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic vec_t mk(input int xi, input int mi, input int yi);
      vec_t v;
      v.x = 5'(xi);
      v.m = 2'(mi);
      v.y = 5'(yi);
      return v;
   endfunction
   // watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   // main test sequence
   initial begin
      bit acc, outv;
      int yo, prev, nxt;
      tv.push_back(mk(-5, 0, -4));  tv.push_back(mk(-5, 1, -5));  tv.push_back(mk(-5, 2, -4));
      tv.push_back(mk(15, 0, 13));  tv.push_back(mk(-16, 1, -14)); tv.push_back(mk(15, 1, 13));
      tv.push_back(mk(15, 2, 13));  tv.push_back(mk(3, 0, 2));     tv.push_back(mk(3, 1, 2));
      tv.push_back(mk(3, 2, 3));    tv.push_back(mk(-3, 0, -2));   tv.push_back(mk(-3, 1, -3));
      tv.push_back(mk(-3, 2, -3));  tv.push_back(mk(-3, 3, -2));   tv.push_back(mk(4, 2, 4));
      tv.push_back(mk(4, 0, 3));    tv.push_back(mk(-4, 2, -3));   tv.push_back(mk(-4, 1, -4));
      tv.push_back(mk(-4, 0, -3));  tv.push_back(mk(1, 2, 1));     tv.push_back(mk(-1, 0, 0));
      tv.push_back(mk(-1, 1, -1));  tv.push_back(mk(-1, 2, -1));   tv.push_back(mk(-1, 3, 0));
      tv.push_back(mk(-16, 0, -14)); tv.push_back(mk(-16, 2, -14)); tv.push_back(mk(0, 2, 0));
      x = 5'd7;
      mode = 2'd0;
      x_valid = 1'b1;
      y_ready = 1'b0;
      #2 reset = 1'b0;
      #10;
      chk("rst_y_valid", y_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_x_ready", x_ready, 1);
      y_ready = 1'b1;
      x_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < tv.size() + 2; c++) begin
         if (c < tv.size()) begin
            x = tv[c].x;
            mode = tv[c].m;
            x_valid = 1'b1;
         end else x_valid = 1'b0;
         tick;
         if (c >= 2) begin
            chk($sformatf("tbl%0d_valid", c - 2), y_valid, 1);
            chk($sformatf("tbl%0d_y", c - 2), y, tv[c-2].y);
         end else chk($sformatf("lat%0d_valid", c), y_valid, 0);
      end
      x_valid = 1'b0;
      chk("tbl_ovf", ovf, 0);
      tick;
      tick;
      tick;
      nxt = 1;
      prev = 0;
      for (int c = 0; c < 40 && got.size() < 8; c++) begin
         y_ready = !(c >= 5 && c <= 7);
         x_valid = nxt <= 8;
         x = 5'(nxt);
         mode = 2'd0;
         #1;
         if (c >= 5 && c <= 7) chk($sformatf("stall%0d_x_ready", c), x_ready, 0);
         if (c >= 6 && c <= 8) chk($sformatf("stall%0d_hold", c), y, prev);
         prev = y;
         acc = x_valid && x_ready;
         outv = y_valid && y_ready;
         yo = y;
         tick;
         if (acc) nxt++;
         if (outv) got.push_back(yo);
      end
      x_valid = 1'b0;
      y_ready = 1'b1;
      chk("stream_count", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++) chk($sformatf("stream%0d_y", i), got[i], i);
      tick;
      tick;
      tick;
      tick;
      for (int i = 0; i < 3; i++) begin
         x = 5'(2 + i);
         mode = 2'd0;
         x_valid = 1'b1;
         tick;
      end
      x_valid = 1'b0;
      chk("inflight_valid", y_valid, 1);
      chk("inflight_y", y, 1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_y_valid", y_valid, 0);
      chk("midrst_y", y, 0);
      chk("midrst_x_ready", x_ready, 1);
      #1 reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick;
         chk($sformatf("stale%0d_valid", c), y_valid, 0);
      end
      x = 5'd6;
      mode = 2'd2;
      x_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         x_valid = 1'b0;
         chk($sformatf("relat%0d_valid", c), y_valid, c == 2 ? 1 : 0);
      end
      chk("relat_y", y, 5);
      reset = 1'b0;
      #2 reset = 1'b1;
      chk("k9_ovf_reset", ovfk, 0);
      x = 5'd15;
      mode = 2'd0;
      x_valid = 1'b1;
      tick;
      x = 5'd1;
      tick;
      x_valid = 1'b0;
      chk("k9_ovf_early", ovfk, 0);
      tick;
      chk("k9_y_valid", yk_valid, 1);
      chk("k9_y", yk, K9_Y);
      chk("k9_ovf_set", ovfk, 1);
      chk("k7_y", y, 13);
      chk("k7_ovf", ovf, 0);
      tick;
      chk("k9_y_inrange", yk, 1);
      chk("k9_ovf_held", ovfk, 1);
      tick;
      tick;
      chk("k9_ovf_sticky", ovfk, 1);
      chk("k9_bubble_valid", yk_valid, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cmul_frac_pipe.md
CMUL_FRAC_PIPE -- requirements
Module: cmul_frac_pipe

Interface
REQ-001 The block SHALL have parameter W, default 5: signed data width of x and y, legal range 4..24.
REQ-002 The block SHALL have parameter K, default 7: positive integer coefficient numerator, legal range 1..255.
REQ-003 The block SHALL have parameter S, default 3: coefficient denominator exponent, the divisor being 2^S, legal range 1..8.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port x, input, W bits: signed two's-complement sample.
REQ-007 The block SHALL have port mode, input, 2 bits: rounding mode, sampled together with x.
REQ-008 The block SHALL have port x_valid, input, 1 bit: x and mode are valid this cycle.
REQ-009 The block SHALL have port x_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-010 The block SHALL have port y, output, W bits: signed result, round(x*K/2^S).
REQ-011 The block SHALL have port y_valid, output, 1 bit: y holds a valid result.
REQ-012 The block SHALL have port y_ready, input, 1 bit: downstream accepts y this cycle.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, set when any result exceeded the W-bit range.

Function
REQ-014 The datapath SHALL be a 3-stage pipeline: S1 registers x, mode and valid; S2 registers the exact product p = x*K at width W+8; S3 registers the scaled, rounded and range-limited y.
REQ-015 Latency SHALL be exactly 3 clk cycles from an accepted sample (x_valid & x_ready) to y_valid when no stall occurs.
REQ-016 The pipeline enable SHALL be en = y_ready | ~y_valid; all stages advance only when en=1, and x_ready SHALL equal en.
REQ-017 When en=0, all stage registers and y SHALL hold; a sample SHALL be neither lost nor duplicated.
REQ-018 Bubbles (x_valid=0) SHALL propagate as invalid stage entries.
REQ-019 Throughput SHALL be one sample per cycle while y_ready=1.
REQ-020 mode=0 SHALL truncate toward zero, identical to signed integer division p/2^S.
REQ-021 mode=1 SHALL round toward minus infinity, i.e. an arithmetic shift p>>>S.
REQ-022 mode=2 SHALL round to nearest with ties toward plus infinity, i.e. (p+2^(S-1))>>>S.
REQ-023 mode=3 SHALL behave as mode=0.
REQ-024 Each sample SHALL use its own mode, carried through the pipeline with it; a mode change between samples SHALL take effect per sample.
REQ-025 Range check: a scaled value q outside [-2^(W-1), 2^(W-1)-1] SHALL set ovf when that sample's result is registered in S3; the range-limited y value is defined under Configuration.
REQ-026 ovf SHALL remain 1 until reset.
REQ-027 A result within range SHALL never set ovf.

Reset
REQ-028 While reset=0, y SHALL be 0, y_valid 0, ovf 0, all stage valids 0 and all stage data 0, asynchronously.
REQ-029 An assertion of reset mid-operation SHALL discard all in-flight samples; x_ready SHALL equal 1 during reset.
REQ-030 After reset deasserts, the first accepted sample SHALL appear exactly 3 cycles later.

Configuration
REQ-031 With macro CMUL_FRAC_SAT_EN defined, an out-of-range q SHALL saturate to 2^(W-1)-1 or -2^(W-1).
REQ-032 Without CMUL_FRAC_SAT_EN, an out-of-range q SHALL wrap, y being the low W bits of q; ovf behaviour SHALL be identical in both builds.

Verification
REQ-033 W=5,K=7,S=3, x=-5, modes 0/1/2 back-to-back -> y=-4, -5, -4 on 3 consecutive cycles starting 3 cycles after the first.
REQ-034 x=15 mode 0 -> y=13; x=-16 mode 1 -> y=-14; ovf stays 0.
REQ-035 K=9, x=15 mode 0 -> with CMUL_FRAC_SAT_EN y=15, without y=-16 (q=16 wrapped); ovf=1 and held in both builds.
REQ-036 Stream x=1..8 with y_ready low for cycles 5-7 -> x_ready low in the same cycles, output sequence complete, in order and without duplicates.
REQ-037 Reset pulsed low while 3 samples are in flight -> y_valid=0 and y=0 immediately, no stale output afterwards, next sample has 3-cycle latency.
